sram_port_arbiter: RTL and testbench

Controller that sequences the 32x256 1RW+1R sky130 SRAM macro and shares it between requesters. Port 0 (RW) is shared round-robin between two masters (A: core load/store, B: loader/debug); port 1 (R-only) serves a single fetch master. The block converts valid/ready requests into the macro's active-low csb/web, registered-input timing and returns read data with a fixed two-cycle latency.

---
 rtl/sram_ctrl_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 30 +++
 rtl/sram_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths, request struct and owner tag for the SRAM port controller
package sram_ctrl_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_WMASKS = DATA_WIDTH / 8;

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter; the side not granted last wins a tie
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_b_q;
  logic last_b_d;

  // last_b_q resets high so that A wins the first tie
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_b_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_b_d = last_b_q;
    if (grant != 2'b00) last_b_d = grant[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_b_q <= 1'b1;
    else       last_b_q <= last_b_d;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares the 1RW+1R SRAM macro between two RW masters and one fetch master
module sram_port_arbiter #(
  parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
  parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [NUM_WMASKS-1:0] b_req_wmask,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  input  logic                  f_req_valid,
  output logic                  f_req_ready,
  input  logic [ADDR_WIDTH-1:0] f_req_addr,
  output logic                  f_rsp_valid,
  output logic [DATA_WIDTH-1:0] f_rsp_rdata,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  import sram_ctrl_pkg::*;

  logic [1:0] grant;
  req_t       a_req;
  req_t       b_req;
  req_t       sel_req;
  logic       any_grant;
  logic       wr_hazard;
  logic       f_fire;

  logic                  csb0_q, csb0_d, web0_q, web0_d;
  logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
  logic [DATA_WIDTH-1:0] din0_q, din0_d;
  owner_t                own0_q, own0_d, own1_q, own1_d;
  logic                  csb1_q, csb1_d;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic                  p0_rd_q, p0_rd_d, f_rd_q, f_rd_d;
  logic                  a_rsp_valid_q, a_rsp_valid_d, b_rsp_valid_q, b_rsp_valid_d;
  logic                  f_rsp_valid_q, f_rsp_valid_d;
  logic [DATA_WIDTH-1:0] a_rsp_rdata_q, a_rsp_rdata_d, b_rsp_rdata_q, b_rsp_rdata_d;
  logic [DATA_WIDTH-1:0] f_rsp_rdata_q, f_rsp_rdata_d;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({b_req_valid, a_req_valid}),
    .grant (grant)
  );

  assign a_req       = '{we: a_req_we, wmask: a_req_wmask, addr: a_req_addr, wdata: a_req_wdata};
  assign b_req       = '{we: b_req_we, wmask: b_req_wmask, addr: b_req_addr, wdata: b_req_wdata};
  assign sel_req     = grant[1] ? b_req : a_req;
  assign any_grant   = |grant;
  assign a_req_ready = grant[0];
  assign b_req_ready = grant[1];

  // A same-word write/read in one macro cycle is undefined, so the fetch waits a cycle
  assign wr_hazard   = any_grant && sel_req.we && (sel_req.addr == f_req_addr);
  assign f_req_ready = ~wr_hazard;
  assign f_fire      = f_req_valid && f_req_ready;

  always_comb begin
    csb0_d   = 1'b1;
    web0_d   = 1'b1;
    wmask0_d = wmask0_q;
    addr0_d  = addr0_q;
    din0_d   = din0_q;
    own0_d   = own0_q;
    if (any_grant) begin
      csb0_d   = 1'b0;
      web0_d   = ~sel_req.we;
      wmask0_d = sel_req.we ? sel_req.wmask : '0;
      addr0_d  = sel_req.addr;
      din0_d   = sel_req.wdata;
      own0_d   = grant[1] ? OWN_B : OWN_A;
    end
    csb1_d  = ~f_fire;
    addr1_d = f_fire ? f_req_addr : addr1_q;

    // Stage 1 marks the cycle the macro captured a read; dout is valid by the next edge
    p0_rd_d = ~csb0_q & web0_q;
    own1_d  = own0_q;
    f_rd_d  = ~csb1_q;

    a_rsp_valid_d = p0_rd_q && (own1_q == OWN_A);
    b_rsp_valid_d = p0_rd_q && (own1_q == OWN_B);
    f_rsp_valid_d = f_rd_q;
    a_rsp_rdata_d = a_rsp_valid_d ? sram_dout0 : a_rsp_rdata_q;
    b_rsp_rdata_d = b_rsp_valid_d ? sram_dout0 : b_rsp_rdata_q;
    f_rsp_rdata_d = f_rsp_valid_d ? sram_dout1 : f_rsp_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb0_q        <= 1'b1;
      web0_q        <= 1'b1;
      wmask0_q      <= '0;
      addr0_q       <= '0;
      din0_q        <= '0;
      own0_q        <= OWN_A;
      own1_q        <= OWN_A;
      csb1_q        <= 1'b1;
      addr1_q       <= '0;
      p0_rd_q       <= 1'b0;
      f_rd_q        <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      f_rsp_valid_q <= 1'b0;
      a_rsp_rdata_q <= '0;
      b_rsp_rdata_q <= '0;
      f_rsp_rdata_q <= '0;
    end else begin
      csb0_q        <= csb0_d;
      web0_q        <= web0_d;
      wmask0_q      <= wmask0_d;
      addr0_q       <= addr0_d;
      din0_q        <= din0_d;
      own0_q        <= own0_d;
      own1_q        <= own1_d;
      csb1_q        <= csb1_d;
      addr1_q       <= addr1_d;
      p0_rd_q       <= p0_rd_d;
      f_rd_q        <= f_rd_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      f_rsp_valid_q <= f_rsp_valid_d;
      a_rsp_rdata_q <= a_rsp_rdata_d;
      b_rsp_rdata_q <= b_rsp_rdata_d;
      f_rsp_rdata_q <= f_rsp_rdata_d;
    end
  end

  assign sram_csb0   = csb0_q;
  assign sram_web0   = web0_q;
  assign sram_wmask0 = wmask0_q;
  assign sram_addr0  = addr0_q;
  assign sram_din0   = din0_q;
  assign sram_csb1   = csb1_q;
  assign sram_addr1  = addr1_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign a_rsp_rdata = a_rsp_rdata_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign b_rsp_rdata = b_rsp_rdata_q;
  assign f_rsp_valid = f_rsp_valid_q;
  assign f_rsp_rdata = f_rsp_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed scoreboard bench with a behavioural 1RW+1R SRAM macro
module tb_sram_port_arbiter;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [3:0]  a_req_wmask;
  logic [7:0]  a_req_addr;
  logic [31:0] a_req_wdata, a_rsp_rdata;
  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [3:0]  b_req_wmask;
  logic [7:0]  b_req_addr;
  logic [31:0] b_req_wdata, b_rsp_rdata;
  logic        f_req_valid, f_req_ready, f_rsp_valid;
  logic [7:0]  f_req_addr;
  logic [31:0] f_rsp_rdata;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        exp_q[3][$];
  logic [31:0] mem_ref [256];
  string       nm[3] = '{"a", "b", "f"};

  sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_rdata(f_rsp_rdata),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] preload(input int i);
    case (i)
      2:       return 32'hFD010113;
      3:       return 32'h00112623;
      4:       return 32'h00812423;
      5:       return 32'h01010413;
      default: return 32'h0;
    endcase
  endfunction

  // Macro model: inputs latched at posedge, dout X until the negedge that performs the access
  logic [31:0] mem [256];
  logic        m_csb0, m_web0, m_csb1;
  logic [3:0]  m_wmask0;
  logic [7:0]  m_addr0, m_addr1;
  logic [31:0] m_din0;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = preload(i);
    sram_dout0 = '0;
    sram_dout1 = '0;
    forever begin
      @(posedge clk);
      m_csb0   <= sram_csb0;
      m_web0   <= sram_web0;
      m_wmask0 <= sram_wmask0;
      m_addr0  <= sram_addr0;
      m_din0   <= sram_din0;
      m_csb1   <= sram_csb1;
      m_addr1  <= sram_addr1;
      if (!sram_csb0) sram_dout0 <= 'x;
      if (!sram_csb1) sram_dout1 <= 'x;
      @(negedge clk);
      if (!m_csb1)
        sram_dout1 = (!m_csb0 && !m_web0 && m_addr0 == m_addr1) ? 'x : mem[m_addr1];
      if (!m_csb0 && !m_web0) begin
        for (int j = 0; j < 4; j++)
          if (m_wmask0[j]) mem[m_addr0][8*j +: 8] = m_din0[8*j +: 8];
      end
      if (!m_csb0 && m_web0) sram_dout0 = mem[m_addr0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    if (v) begin
      if (exp_q[p].size() == 0) begin
        check($sformatf("%s_rsp_unexpected", nm[p]), 32'(v), 32'd0);
      end else begin
        e = exp_q[p].pop_front();
        check($sformatf("%s_rsp_data", nm[p]), d, e.data);
        check($sformatf("%s_rsp_cycle", nm[p]), 32'(cyc), e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_rsp_valid, a_rsp_rdata);
    mon(1, b_rsp_valid, b_rsp_rdata);
    mon(2, f_rsp_valid, f_rsp_rdata);
  end

  task automatic accept(input int p, input logic we, input logic [3:0] m,
                        input logic [7:0] ad, input logic [31:0] d);
    exp_t e;
    if (we) begin
      for (int j = 0; j < 4; j++)
        if (m[j]) mem_ref[ad][8*j +: 8] = d[8*j +: 8];
    end else begin
      e.cyc  = 32'(cyc + 3);
      e.data = mem_ref[ad];
      exp_q[p].push_back(e);
    end
  endtask

  task automatic set_a(input logic v, input logic we, input logic [3:0] m,
                       input logic [7:0] ad, input logic [31:0] d);
    a_req_valid = v; a_req_we = we; a_req_wmask = m; a_req_addr = ad; a_req_wdata = d;
  endtask

  task automatic set_b(input logic v, input logic we, input logic [3:0] m,
                       input logic [7:0] ad, input logic [31:0] d);
    b_req_valid = v; b_req_we = we; b_req_wmask = m; b_req_addr = ad; b_req_wdata = d;
  endtask

  task automatic set_f(input logic v, input logic [7:0] ad);
    f_req_valid = v; f_req_addr = ad;
  endtask

  // Called just after a negedge: lets readies settle and records what the next edge accepts
  task automatic settle();
    exp_t e;
    #1;
    if (!reset) begin
      if (f_req_valid && f_req_ready) begin
        e.cyc  = 32'(cyc + 3);
        e.data = mem_ref[f_req_addr];
        exp_q[2].push_back(e);
      end
      if (a_req_valid && a_req_ready) accept(0, a_req_we, a_req_wmask, a_req_addr, a_req_wdata);
      if (b_req_valid && b_req_ready) accept(1, b_req_we, b_req_wmask, b_req_addr, b_req_wdata);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    set_a(0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0);
    set_f(0, 0);
    repeat (n) begin
      settle();
      next();
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_csb0"}, 32'(sram_csb0), 32'd1);
    check({pfx, "_web0"}, 32'(sram_web0), 32'd1);
    check({pfx, "_csb1"}, 32'(sram_csb1), 32'd1);
    check({pfx, "_wmask0"}, 32'(sram_wmask0), 32'd0);
    check({pfx, "_addr0"}, 32'(sram_addr0), 32'd0);
    check({pfx, "_din0"}, sram_din0, 32'd0);
    check({pfx, "_addr1"}, 32'(sram_addr1), 32'd0);
    check({pfx, "_rsp_valids"}, 32'({a_rsp_valid, b_rsp_valid, f_rsp_valid}), 32'd0);
    check({pfx, "_a_rdata"}, a_rsp_rdata, 32'd0);
    check({pfx, "_b_rdata"}, b_rsp_rdata, 32'd0);
    check({pfx, "_f_rdata"}, f_rsp_rdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_ref[i] = preload(i);
    set_a(1, 0, 0, 8'h02, 0);
    set_b(1, 0, 0, 8'h03, 0);
    set_f(0, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");

    // Both held valid out of reset: A, B, A
    reset = 1'b0;
    settle();
    check("rr0_a_ready", 32'(a_req_ready), 32'd1);
    check("rr0_b_ready", 32'(b_req_ready), 32'd0);
    next();
    settle();
    check("rr1_a_ready", 32'(a_req_ready), 32'd0);
    check("rr1_b_ready", 32'(b_req_ready), 32'd1);
    check("rr1_csb0", 32'(sram_csb0), 32'd0);
    check("rr1_addr0", 32'(sram_addr0), 32'h02);
    next();
    settle();
    check("rr2_a_ready", 32'(a_req_ready), 32'd1);
    check("rr2_b_ready", 32'(b_req_ready), 32'd0);
    next();
    idle(3);

    // Masked write then read of the same word
    set_a(1, 1, 4'b0011, 8'h10, 32'hDEADBEEF);
    settle();
    check("wr_a_ready", 32'(a_req_ready), 32'd1);
    next();
    set_a(1, 0, 0, 8'h10, 0);
    settle();
    check("wr_web0", 32'(sram_web0), 32'd0);
    check("wr_wmask0", 32'(sram_wmask0), 32'h3);
    check("wr_addr0", 32'(sram_addr0), 32'h10);
    check("wr_din0", sram_din0, 32'hDEADBEEF);
    next();
    idle(3);
    check("wr_rd_rdata", a_rsp_rdata, 32'h0000BEEF);

    // B streams reads of program words
    for (int i = 2; i <= 5; i++) begin
      set_b(1, 0, 0, 8'(i), 0);
      settle();
      check("stream_b_ready", 32'(b_req_ready), 32'd1);
      next();
    end
    idle(4);
    check("stream_last_rdata", b_rsp_rdata, 32'h01010413);

    // Fetch colliding with a write to the same word
    set_a(1, 1, 4'hF, 8'h20, 32'hCAFEF00D);
    set_f(1, 8'h20);
    settle();
    check("haz_f_ready", 32'(f_req_ready), 32'd0);
    check("haz_a_ready", 32'(a_req_ready), 32'd1);
    next();
    set_a(0, 0, 0, 0, 0);
    settle();
    check("haz_retry_f_ready", 32'(f_req_ready), 32'd1);
    next();
    idle(4);
    check("haz_f_rdata", f_rsp_rdata, 32'hCAFEF00D);

    // Fetch and A read of different words in the same cycle
    set_a(1, 0, 0, 8'h10, 0);
    set_f(1, 8'h03);
    settle();
    check("dual_a_ready", 32'(a_req_ready), 32'd1);
    check("dual_f_ready", 32'(f_req_ready), 32'd1);
    next();
    idle(4);
    check("dual_f_rdata", f_rsp_rdata, 32'h00112623);

    // Reset one cycle after a B read is accepted
    set_b(1, 0, 0, 8'h04, 0);
    settle();
    check("mid_b_ready", 32'(b_req_ready), 32'd1);
    next();
    set_b(0, 0, 0, 0, 0);
    reset = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    exp_q[2].delete();
    #1;
    check_reset_outputs("midrst");
    repeat (4) @(negedge clk);
    check_reset_outputs("midrst_hold");
    set_a(1, 0, 0, 8'h05, 0);
    set_b(1, 0, 0, 8'h03, 0);
    reset = 1'b0;
    settle();
    check("post_a_ready", 32'(a_req_ready), 32'd1);
    check("post_b_ready", 32'(b_req_ready), 32'd0);
    next();
    settle();
    check("post2_b_ready", 32'(b_req_ready), 32'd1);
    next();
    idle(5);

    check("a_pending", 32'(exp_q[0].size()), 32'd0);
    check("b_pending", 32'(exp_q[1].size()), 32'd0);
    check("f_pending", 32'(exp_q[2].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
